// File: rtl/register_16bit.sv
// register_16bit: WIDTH-bit PIPO hold register, optional even-parity bit p (REGISTER_16BIT_PARITY_EN).
// Latency: 1 clk from i to o/p; rst (async, active-high) forces RESET_VALUE at once.
// Backpressure: none -- every rising edge loads, no enable or handshake.
module register_16bit #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o
`ifdef REGISTER_16BIT_PARITY_EN
    ,
    output logic             p
`endif
);

`ifdef REGISTER_16BIT_PARITY_EN
    // Parity shares the data register's block so o and p can never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o <= RESET_VALUE;
            p <= ^RESET_VALUE;
        end else begin
            o <= i;
            p <= ^i;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o <= RESET_VALUE;
        end else begin
            o <= i;
        end
    end
`endif

endmodule

// File: tb/tb_register_16bit.sv
// Randomized self-checking bench for register_16bit; expected data comes from a queue of driven values.
module tb_register_16bit;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] i;
    logic [W-1:0] o;
`ifdef REGISTER_16BIT_PARITY_EN
    logic         p;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_q[$];

    register_16bit #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .i   (i),
        .o   (o)
`ifdef REGISTER_16BIT_PARITY_EN
        ,
        .p   (p)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Even parity by counting ones, independent of the reduction operator.
    function automatic logic parity_of(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < W; k++) if (v[k] == 1'b1) n++;
        return (n % 2) == 1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        i   = 16'h0000;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_before_edge: o=%h expected=%h", o, 16'h0000);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i = W'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (o !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold: o=%h expected=%h i=%h", o, 16'h0000, i);
            end
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        rst = 1'b0;
        i   = 16'h0001;
        #1;
        checks++;
        if (o !== 16'h0000) begin
            errors++;
            $display("FAIL release_before_edge: o=%h expected=%h", o, 16'h0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o !== 16'h0001) begin
            errors++;
            $display("FAIL release_first_capture: o=%h expected=%h", o, 16'h0001);
        end
    endtask

    task automatic test_capture(input int n, input logic use_fixed);
        logic [W-1:0] v;
        logic [W-1:0] exp;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            v = use_fixed ? W'(16'h0002 << c) : W'($urandom);
            i = v;
            model_q.push_back(v);
            @(posedge clk);
            #1;
            exp = model_q.pop_front();
            checks++;
            if (o !== exp) begin
                errors++;
                $display("FAIL capture[%0d]: o=%h expected=%h", c, o, exp);
            end
`ifdef REGISTER_16BIT_PARITY_EN
            checks++;
            if (p !== parity_of(exp)) begin
                errors++;
                $display("FAIL capture_parity[%0d]: p=%b expected=%b data=%h", c, p, parity_of(exp), exp);
            end
`endif
        end
    endtask

    task automatic test_midcycle_reset();
        logic [W-1:0] v;
        @(negedge clk);
        i = 16'hFFFF;
        @(posedge clk);
        #1;
        checks++;
        if (o !== 16'hFFFF) begin
            errors++;
            $display("FAIL pre_reset_capture: o=%h expected=%h", o, 16'hFFFF);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o !== 16'h0000) begin
            errors++;
            $display("FAIL midcycle_reset_immediate: o=%h expected=%h", o, 16'h0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o !== 16'h0000) begin
            errors++;
            $display("FAIL midcycle_reset_hold: o=%h expected=%h", o, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        v   = W'($urandom);
        i   = v;
        #1;
        checks++;
        if (o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release_no_edge: o=%h expected=%h", o, 16'h0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o !== v) begin
            errors++;
            $display("FAIL reset_release_capture: o=%h expected=%h", o, v);
        end
    endtask

    task automatic test_hold_between_edges();
        logic [W-1:0] v;
        @(negedge clk);
        v = W'($urandom);
        i = v;
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            #1 i = c[0] ? 16'h5A5A : 16'hA5A5;
            checks++;
            if (o !== v) begin
                errors++;
                $display("FAIL hold_between_edges[%0d]: o=%h expected=%h", c, o, v);
            end
        end
    endtask

`ifdef REGISTER_16BIT_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        i = 16'h0007;
        @(posedge clk);
        #1;
        checks++;
        if (p !== 1'b1) begin
            errors++;
            $display("FAIL parity_0007: p=%b expected=1", p);
        end
        @(negedge clk);
        i = 16'h0003;
        @(posedge clk);
        #1;
        checks++;
        if (p !== 1'b0) begin
            errors++;
            $display("FAIL parity_0003: p=%b expected=0", p);
        end
        @(negedge clk);
        i = 16'h0001;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (p !== 1'b0) begin
            errors++;
            $display("FAIL parity_reset: p=%b expected=0", p);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_release();
        test_capture(2, 1'b1);
        test_capture(24, 1'b0);
        test_midcycle_reset();
        test_hold_between_edges();
        test_capture(8, 1'b0);
`ifdef REGISTER_16BIT_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
